// File: rtl/traffic_light_fsm_if.sv
// Signal bundle between the traffic-light controller and its environment.
// The controller takes the slave side. Tick and sensor inputs flow in, and lamp and phase status flow out.
interface traffic_light_fsm_if;
  logic       tick;
  logic       ew_car;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic       phase_done;

  modport master (
    output tick,
    output ew_car,
    input  ns_light,
    input  ew_light,
    input  phase,
    input  phase_done
  );

  modport slave (
    input  tick,
    input  ew_car,
    output ns_light,
    output ew_light,
    output phase,
    output phase_done
  );
endinterface

// File: rtl/traffic_light_fsm.sv
// Two-axis traffic-light controller timed by an external tick enable.
// North-south green holds until an east-west car is sensed at green expiry.
module traffic_light_fsm #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2
) (
  input  logic                clk,
  input  logic                rst,
  traffic_light_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    ALLR1 = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    ALLR2 = 3'd5
  } state_t;

  localparam logic [3:0] GREEN_LD  = 4'(GREEN_TICKS - 1);
  localparam logic [3:0] YELLOW_LD = 4'(YELLOW_TICKS - 1);
  localparam logic [3:0] ALLRED_LD = 4'(ALLRED_TICKS - 1);

  state_t     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic       done_q, done_d;
  logic [2:0] ns_q, ew_q;
  logic       expire;

  // Lamp encoding is {red, yellow, green}; only the two green states light a green bit.
  function automatic logic [2:0] ns_lamp(input state_t s);
    case (s)
      NS_G:    return 3'b001;
      NS_Y:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(input state_t s);
    case (s)
      EW_G:    return 3'b001;
      EW_Y:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    expire  = bus.tick && (timer_q == 4'd0);
    if (bus.tick && (timer_q != 4'd0)) timer_d = timer_q - 4'd1;
    case (state_q)
      NS_G: if (expire) begin
        // Without a waiting east-west car, green is simply re-armed for another period.
        if (bus.ew_car) begin
          state_d = NS_Y;
          timer_d = YELLOW_LD;
          done_d  = 1'b1;
        end else begin
          timer_d = GREEN_LD;
        end
      end
      NS_Y: if (expire) begin
        state_d = ALLR1;
        timer_d = ALLRED_LD;
        done_d  = 1'b1;
      end
      ALLR1: if (expire) begin
        state_d = EW_G;
        timer_d = GREEN_LD;
        done_d  = 1'b1;
      end
      EW_G: if (expire) begin
        state_d = EW_Y;
        timer_d = YELLOW_LD;
        done_d  = 1'b1;
      end
      EW_Y: if (expire) begin
        state_d = ALLR2;
        timer_d = ALLRED_LD;
        done_d  = 1'b1;
      end
      ALLR2: if (expire) begin
        state_d = NS_G;
        timer_d = GREEN_LD;
        done_d  = 1'b1;
      end
      default: begin
        // Corrupted codes recover to a safe all-red state at once, whatever the tick does.
        state_d = ALLR2;
        timer_d = ALLRED_LD;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALLR2;
      timer_q <= ALLRED_LD;
      done_q  <= 1'b0;
      ns_q    <= 3'b100;
      ew_q    <= 3'b100;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      ns_q    <= ns_lamp(state_d);
      ew_q    <= ew_lamp(state_d);
    end
  end

  assign bus.ns_light   = ns_q;
  assign bus.ew_light   = ew_q;
  assign bus.phase      = state_q;
  assign bus.phase_done = done_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with default durations (8/3/2 ticks).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_traffic_light_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  traffic_light_fsm_if bus ();

  traffic_light_fsm #(
    .GREEN_TICKS (8),
    .YELLOW_TICKS(3),
    .ALLRED_TICKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  localparam logic [2:0] NS_TAB [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  localparam logic [2:0] EW_TAB [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  // Phase reached after k consecutive ticks following reset, with ew_car held high.
  function automatic int exp_phase(input int k);
    if (k < 2)  return 5;
    if (k < 10) return 0;
    if (k < 13) return 1;
    if (k < 15) return 2;
    if (k < 23) return 3;
    if (k < 26) return 4;
    if (k < 28) return 5;
    return 0;
  endfunction

  function automatic bit is_trans(input int k);
    return (k == 2) || (k == 10) || (k == 13) || (k == 15) || (k == 23) || (k == 26) || (k == 28);
  endfunction

  // Called aligned to a falling edge: drive tick, let one rising edge pass, return on next falling edge.
  task automatic cyc(input logic t);
    bus.tick = t;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic tick_then_idle();
    cyc(1'b1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (bus.ns_light[0] && bus.ew_light[0]) begin
        bad++;
        $display("FAIL both_green: ns=%b ew=%b required at most one green", bus.ns_light, bus.ew_light);
      end
      total++;
      if (!$onehot(bus.ns_light) || !$onehot(bus.ew_light)) begin
        bad++;
        $display("FAIL onehot: ns=%b ew=%b required one-hot", bus.ns_light, bus.ew_light);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.tick = 1'b1;
    bus.ew_car = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.tick = 1'b0;
    total++;
    if (bus.ns_light !== 3'b100 || bus.ew_light !== 3'b100 || bus.phase !== 3'd5 || bus.phase_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ns=%b ew=%b phase=%0d done=%b required 100 100 5 0",
               bus.ns_light, bus.ew_light, bus.phase, bus.phase_done);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_sequence();
    apply_reset();
    bus.ew_car = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      tick_then_idle();
      total++;
      if (bus.phase !== 3'(exp_phase(k)) || bus.phase_done !== is_trans(k)) begin
        bad++;
        $display("FAIL seq_tick%0d: phase=%0d done=%b required %0d %b",
                 k, bus.phase, bus.phase_done, exp_phase(k), is_trans(k));
      end
      total++;
      if (bus.ns_light !== NS_TAB[exp_phase(k)] || bus.ew_light !== EW_TAB[exp_phase(k)]) begin
        bad++;
        $display("FAIL seq_lamps%0d: ns=%b ew=%b required %b %b",
                 k, bus.ns_light, bus.ew_light, NS_TAB[exp_phase(k)], EW_TAB[exp_phase(k)]);
      end
      for (int j = 0; j < 3; j++) begin
        cyc(1'b0);
        total++;
        if (bus.phase !== 3'(exp_phase(k)) || bus.phase_done !== 1'b0) begin
          bad++;
          $display("FAIL seq_idle%0d_%0d: phase=%0d done=%b required %0d 0",
                   k, j, bus.phase, bus.phase_done, exp_phase(k));
        end
      end
    end
  endtask

  task automatic test_extension();
    apply_reset();
    bus.ew_car = 1'b0;
    tick_then_idle();
    tick_then_idle();
    for (int k = 1; k <= 24; k++) begin
      tick_then_idle();
      total++;
      if (bus.phase !== 3'd0 || bus.phase_done !== 1'b0 || bus.ns_light !== 3'b001) begin
        bad++;
        $display("FAIL ext_hold%0d: phase=%0d done=%b ns=%b required 0 0 001",
                 k, bus.phase, bus.phase_done, bus.ns_light);
      end
    end
    bus.ew_car = 1'b1;
    for (int k = 1; k <= 7; k++) tick_then_idle();
    total++;
    if (bus.phase !== 3'd0) begin
      bad++;
      $display("FAIL ext_before_expiry: phase=%0d required 0", bus.phase);
    end
    tick_then_idle();
    total++;
    if (bus.phase !== 3'd1 || bus.phase_done !== 1'b1 || bus.ns_light !== 3'b010) begin
      bad++;
      $display("FAIL ext_release: phase=%0d done=%b ns=%b required 1 1 010",
               bus.phase, bus.phase_done, bus.ns_light);
    end
  endtask

  task automatic test_freeze();
    apply_reset();
    bus.ew_car = 1'b1;
    for (int k = 1; k <= 18; k++) cyc(1'b1);
    for (int k = 0; k < 100; k++) begin
      bus.ew_car = k[0];
      cyc(1'b0);
      total++;
      if (bus.phase !== 3'd3 || bus.ns_light !== 3'b100 || bus.ew_light !== 3'b001 || bus.phase_done !== 1'b0) begin
        bad++;
        $display("FAIL freeze%0d: phase=%0d ns=%b ew=%b done=%b required 3 100 001 0",
                 k, bus.phase, bus.ns_light, bus.ew_light, bus.phase_done);
      end
    end
    bus.ew_car = 1'b1;
    for (int k = 1; k <= 4; k++) cyc(1'b1);
    total++;
    if (bus.phase !== 3'd3) begin
      bad++;
      $display("FAIL freeze_timer_kept: phase=%0d required 3", bus.phase);
    end
    cyc(1'b1);
    total++;
    if (bus.phase !== 3'd4 || bus.ew_light !== 3'b010 || bus.phase_done !== 1'b1) begin
      bad++;
      $display("FAIL freeze_resume: phase=%0d ew=%b done=%b required 4 010 1",
               bus.phase, bus.ew_light, bus.phase_done);
    end
  endtask

  task automatic test_reset_mid();
    // Entered from test_freeze while sitting in EW_Y with a fresh timer.
    cyc(1'b1);
    rst = 1'b1;
    cyc(1'b1);
    rst = 1'b0;
    total++;
    if (bus.ns_light !== 3'b100 || bus.ew_light !== 3'b100 || bus.phase !== 3'd5 || bus.phase_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_ewy: ns=%b ew=%b phase=%0d done=%b required 100 100 5 0",
               bus.ns_light, bus.ew_light, bus.phase, bus.phase_done);
    end
    cyc(1'b1);
    total++;
    if (bus.phase !== 3'd5) begin
      bad++;
      $display("FAIL rst_ewy_tick1: phase=%0d required 5", bus.phase);
    end
    cyc(1'b1);
    total++;
    if (bus.phase !== 3'd0 || bus.phase_done !== 1'b1) begin
      bad++;
      $display("FAIL rst_ewy_tick2: phase=%0d done=%b required 0 1", bus.phase, bus.phase_done);
    end
    // Reset during an extension expiry, with tick asserted and no car.
    bus.ew_car = 1'b0;
    for (int k = 1; k <= 7; k++) cyc(1'b1);
    rst = 1'b1;
    cyc(1'b1);
    rst = 1'b0;
    total++;
    if (bus.phase !== 3'd5 || bus.ns_light !== 3'b100 || bus.phase_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_ext: phase=%0d ns=%b done=%b required 5 100 0",
               bus.phase, bus.ns_light, bus.phase_done);
    end
  endtask

  task automatic test_continuous();
    int pulses;
    pulses = 0;
    apply_reset();
    bus.ew_car = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      cyc(1'b1);
      if (bus.phase_done === 1'b1) pulses++;
      total++;
      if (bus.phase !== 3'(exp_phase(k)) || bus.phase_done !== is_trans(k)) begin
        bad++;
        $display("FAIL cont_clk%0d: phase=%0d done=%b required %0d %b",
                 k, bus.phase, bus.phase_done, exp_phase(k), is_trans(k));
      end
    end
    total++;
    if (pulses != 7) begin
      bad++;
      $display("FAIL cont_pulses: count=%0d required 7", pulses);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.tick = 1'b0;
    bus.ew_car = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_extension();
    test_freeze();
    test_reset_mid();
    test_continuous();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
